// File: rtl/inst_mem_fetch.sv
// rtl/inst_mem_fetch.sv - instruction memory with registered fetch port and program-load write port
// Optional per-word even parity: define INST_MEM_PARITY_EN.
module inst_mem_fetch #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_seq,
    input  logic [ADDR_W-1:0] ra,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rd,
    output logic [ADDR_W-1:0] rsp_addr,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              rsp_perr
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] fetch_addr;
    logic              accept;

    // Loads own the array for their cycle, so a fetch never reads a word being written.
    assign req_ready  = !load_en && (!rsp_valid || rsp_ready);
    assign accept     = req_valid && req_ready;
    assign fetch_addr = req_seq ? next_addr : ra;

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // The response register is a private copy, so later loads cannot disturb a held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rd        <= '0;
            rsp_addr  <= '0;
            next_addr <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rd        <= mem[fetch_addr];
            rsp_addr  <= fetch_addr;
            next_addr <= fetch_addr + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef INST_MEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (load_en) begin
            par_mem[load_addr] <= ^load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_perr <= 1'b0;
        end else if (accept) begin
            rsp_perr <= (^mem[fetch_addr]) ^ par_mem[fetch_addr];
        end
    end
`else
    assign rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_fetch.sv
// tb/tb_inst_mem_fetch.sv - scoreboard bench for inst_mem_fetch
module tb_inst_mem_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_seq = 1'b0;
    logic [5:0]  ra = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rd;
    logic [5:0]  rsp_addr;
    logic        load_en = 1'b0;
    logic [5:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        rsp_perr;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
        logic        p;
    } item_t;

    item_t       sb_q[$];
    logic [31:0] m_mem [64];
    logic        m_par [64];
    logic        m_valid = 1'b0;
    logic [5:0]  m_next = '0;

    inst_mem_fetch #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_seq(req_seq), .ra(ra),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rd(rd),
        .rsp_addr(rsp_addr), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .rsp_perr(rsp_perr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: decides acceptance from its own state and queues the expected response.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_next  = '0;
            sb_q.delete();
        end else begin
            logic       acc;
            logic [5:0] a;
            item_t      it;
            acc = req_valid && !load_en && (!m_valid || rsp_ready);
            if (load_en) begin
                m_mem[load_addr] = load_data;
                m_par[load_addr] = ^load_data;
            end
            if (acc) begin
                a    = req_seq ? m_next : ra;
                it.a = a;
                it.d = m_mem[a];
`ifdef INST_MEM_PARITY_EN
                it.p = (^m_mem[a]) ^ m_par[a];
`else
                it.p = 1'b0;
`endif
                sb_q.push_back(it);
                m_next  = a + 6'd1;
                m_valid = 1'b1;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check_eq("req_ready", req_ready, !load_en && (!m_valid || rsp_ready));
        check_eq("rsp_valid", rsp_valid, m_valid);
        if (m_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_empty", 1, 0);
            end else begin
                check_eq("rsp_addr", rsp_addr, sb_q[0].a);
                check_eq("rd", rd, sb_q[0].d);
                check_eq("rsp_perr", rsp_perr, sb_q[0].p);
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end else begin
            check_eq("rsp_perr_idle", rsp_perr, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        load_en   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_par[i] = 1'b0;
        #3;
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rd", rd, 0);
        check_eq("rst_rsp_addr", rsp_addr, 0);
        check_eq("rst_rsp_perr", rsp_perr, 0);
        step();
        rst_n = 1'b1;
        // Program load of every word.
        for (int i = 0; i < 64; i++) begin
            load_en   = 1'b1;
            load_addr = 6'(i);
            load_data = $urandom;
            step();
        end
        idle();
        rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            req_valid = 1'b1;
            req_seq   = 1'b0;
            ra        = 6'(i);
            step();
        end
        idle();
        step();
        // Wrap of the sequential address.
        req_valid = 1'b1; req_seq = 1'b0; ra = 6'd62; step();
        req_seq = 1'b1; ra = 6'd10; step();
        step();
        idle();
        step();
        // Backpressure hold, then a load under a held response.
        load_en = 1'b1; load_addr = 6'd5; load_data = 32'hDEADBEEF; step();
        load_en = 1'b0; req_valid = 1'b1; req_seq = 1'b0; ra = 6'd5; step();
        rsp_ready = 1'b0; ra = 6'd9;
        for (int i = 0; i < 4; i++) begin
            step();
            #3;
            check_eq("stall_ready", req_ready, 0);
            check_eq("stall_rd", rd, 32'hDEADBEEF);
        end
        load_en = 1'b1; load_addr = 6'd5; load_data = 32'h12345678; step();
        #3;
        check_eq("held_after_load", rd, 32'hDEADBEEF);
        load_en = 1'b0; rsp_ready = 1'b1; ra = 6'd5; step();
        #3;
        check_eq("refetch_new", rd, 32'h12345678);
        req_seq = 1'b1; step();
        load_en = 1'b1; load_addr = 6'd40; load_data = 32'hCAFE0040; step();
        load_en = 1'b0; step();
        idle();
        step();
        // Reset in the middle of a held response.
        req_valid = 1'b1; req_seq = 1'b0; ra = 6'd33; rsp_ready = 1'b0; step();
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", rsp_valid, 0);
        check_eq("midrst_rd", rd, 0);
        check_eq("midrst_addr", rsp_addr, 0);
        step();
        rst_n = 1'b1; req_valid = 1'b1; req_seq = 1'b1; rsp_ready = 1'b1; step();
        #3;
        check_eq("post_rst_addr", rsp_addr, 0);
        step();
        idle();
        step();
`ifdef INST_MEM_PARITY_EN
        load_en = 1'b1; load_addr = 6'd7; load_data = 32'h00000001; step();
        load_en = 1'b0;
        #2;
        dut.mem[7] = dut.mem[7] ^ 32'h1;
        m_mem[7]   = m_mem[7] ^ 32'h1;
        req_valid = 1'b1; req_seq = 1'b0; ra = 6'd7; step();
        #3;
        check_eq("perr_flip", rsp_perr, 1);
        ra = 6'd8; step();
        #3;
        check_eq("perr_clean", rsp_perr, 0);
        idle();
        step();
`endif
        // Random traffic with interleaved loads and backpressure.
        for (int i = 0; i < 300; i++) begin
            req_valid = 1'($urandom_range(0, 3) != 0);
            req_seq   = 1'($urandom_range(0, 1));
            ra        = 6'($urandom_range(0, 63));
            rsp_ready = 1'($urandom_range(0, 3) != 0);
            load_en   = 1'($urandom_range(0, 7) == 0);
            load_addr = 6'($urandom_range(0, 63));
            load_data = $urandom;
            step();
        end
        idle();
        rsp_ready = 1'b1;
        step();
        step();
        check_eq("drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
